// File: rtl/md_if.sv
// Bundles the execute-stage multiply/divide request, MTHI/MTLO write and result signals.
interface md_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, hi_we, lo_we, wdata,
                    input  busy, done, dz, hi, lo);
    modport slave  (input  start, op, a, b, flush, hi_we, lo_we, wdata,
                    output busy, done, dz, hi, lo);
endinterface

// File: rtl/md_ctrl.sv
// Iterative radix-2 multiply/divide unit that owns HI/LO.
// IDLE: wait for start, MTHI/MTLO allowed | CALC: one step per cycle | FIX: sign-correct, write HI/LO
module md_ctrl #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  reset,
    md_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic               is_div;
    logic               sa;
    logic               sb;
    logic               bz;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               sa_in;
    logic               sb_in;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign sa_in   = ~bus.op[0] & bus.a[WIDTH-1];
    assign sb_in   = ~bus.op[0] & bus.b[WIDTH-1];
    assign abs_a   = sa_in ? -bus.a : bus.a;
    assign abs_b   = sb_in ? -bus.b : bus.b;

    // Multiply keeps the multiplier in acc's low half; divide keeps {rem, quot} in acc.
    assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    assign rem_ge  = rem_sh >= {1'b0, opnd};
    assign rem_sub = rem_sh[WIDTH-1:0] - opnd;

    assign prod_fix = (sa ^ sb) ? -acc : acc;
    assign quot_fix = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            is_div   <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            bz       <= 1'b0;
            a_raw    <= '0;
            opnd     <= '0;
            acc      <= '0;
            cnt      <= '0;
            bus.done <= 1'b0;
            bus.dz   <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) bus.hi <= bus.wdata;
                    if (bus.lo_we) bus.lo <= bus.wdata;
                    if (bus.start && !bus.flush) begin
                        is_div <= bus.op[1];
                        sa     <= sa_in;
                        sb     <= sb_in;
                        bz     <= (bus.b == '0);
                        a_raw  <= bus.a;
                        opnd   <= bus.op[1] ? abs_b : abs_a;
                        acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        if (!is_div)
                            acc <= {add_sum, acc[WIDTH-1:1]};
                        else if (rem_ge)
                            acc <= {rem_sub, acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!bus.flush) begin
                        bus.done <= 1'b1;
                        if (!is_div) begin
                            bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
                            bus.lo <= prod_fix[WIDTH-1:0];
                            bus.dz <= 1'b0;
                        end else if (bz) begin
                            bus.hi <= a_raw;
                            bus.lo <= '1;
                            bus.dz <= 1'b1;
                        end else begin
                            bus.hi <= rem_fix;
                            bus.lo <= quot_fix;
                            bus.dz <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
